elevador_solicitudes: RTL and testbench

//  Upstream request stage for the 3-floor elevator FSM. Debounces the raw floor-call

---
 rtl/elevador_solicitudes.sv | 187 ++++++++++++++++++
 tb/tb_elevador_solicitudes.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevador_solicitudes.sv
// Purpose : request stage for the 3-floor elevator FSM: debounces call buttons, latches
//           pending calls, tracks the car floor and pulses one-floor move commands.
// Latency : press-to-pendiente 2+DEB_CICLOS cycles; boton/dato/puerta_abierta are registered.
// Backpressure: none; the downstream FSM is given TRASLADO_CICLOS per move, no handshake.
// Ports   : clk, rst_n (async active-low); llamada[2:0] raw calls (bit0 = floor 1);
//           motorsubir/motorbajar from the FSM; boton[1:0] (10 up, 01 down) to the FSM;
//           dato[3:0] floor code 1..3; pendiente[2:0] latched calls; puerta_abierta.
// Option  : define RETORNO_PISO1_EN to park the car at floor 1 after REPOSO_CICLOS idle cycles.
module elevador_solicitudes #(
  parameter int DEB_CICLOS      = 16,
  parameter int TRASLADO_CICLOS = 8,
  parameter int PUERTA_CICLOS   = 12,
  parameter int REPOSO_CICLOS   = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] llamada,
  input  logic       motorsubir,
  input  logic       motorbajar,
  output logic [1:0] boton,
  output logic [3:0] dato,
  output logic [2:0] pendiente,
  output logic       puerta_abierta
);

  localparam int DW     = $clog2(DEB_CICLOS + 1);
  localparam int TMAX_A = (TRASLADO_CICLOS > PUERTA_CICLOS) ? TRASLADO_CICLOS : PUERTA_CICLOS;
  localparam int TMAX   = (TMAX_A > REPOSO_CICLOS) ? TMAX_A : REPOSO_CICLOS;
  localparam int TW     = $clog2(TMAX + 1);

  typedef enum logic [1:0] {REPOSO, PEDIR, ESPERA, PUERTA} estado_t;

  // ---------------- input synchronizer + debounce ----------------
  logic [2:0]    r_sync1, r_sync2, r_acc;
  logic [DW-1:0] r_deb_cnt [3];
  logic [2:0]    w_acepta, w_press;

  // A level is accepted on the DEB_CICLOS-th consecutive sample that differs from the
  // last accepted level; the press pulse is combinational so pendiente sets on that edge.
  always_comb begin
    w_acepta = 3'b000;
    for (int i = 0; i < 3; i++) begin
      w_acepta[i] = (r_sync2[i] != r_acc[i]) && (r_deb_cnt[i] == DW'(DEB_CICLOS - 1));
    end
    w_press = w_acepta & r_sync2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
      r_acc   <= 3'b000;
      for (int i = 0; i < 3; i++) r_deb_cnt[i] <= '0;
    end else begin
      r_sync1 <= llamada;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_acc[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (w_acepta[i]) begin
          r_deb_cnt[i] <= '0;
          r_acc[i]     <= r_sync2[i];
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // ---------------- floor tracker ----------------
  logic [1:0] r_piso;
  logic [3:0] r_dato;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_piso <= 2'd1;
      r_dato <= 4'd1;
    end else begin
      if (motorsubir && !motorbajar && r_piso != 2'd3)      r_piso <= r_piso + 2'd1;
      else if (motorbajar && !motorsubir && r_piso != 2'd1) r_piso <= r_piso - 2'd1;
      r_dato <= {2'b00, r_piso};
    end
  end

  // ---------------- scheduler ----------------
  estado_t       r_estado;
  logic          r_dir;      // 1 = up
  logic [TW-1:0] r_timer;    // ESPERA/PUERTA timer, idle counter in REPOSO when enabled
  logic [1:0]    r_boton;
  logic          r_puerta;
  logic [2:0]    r_pend;

  logic [2:0] w_cur, w_arriba, w_abajo, w_blk, w_auto, w_pend_nxt;
  logic       w_llam_cur, w_llam_up, w_llam_dn;

  // Floor masks: piso 1..3 maps to bit 0..2.
  assign w_cur      = 3'b001 << (r_piso - 2'd1);
  assign w_arriba   = 3'b110 << (r_piso - 2'd1);
  assign w_abajo    = ~(w_arriba | w_cur);
  assign w_llam_cur = |(r_pend & w_cur);
  assign w_llam_up  = |(r_pend & w_arriba);
  assign w_llam_dn  = |(r_pend & w_abajo);

  // The current floor's bit is held clear on the cycle the door opens and while it is
  // open, so a press there is absorbed as a door-timer restart instead of a new call.
  assign w_blk      = ((r_estado == PUERTA) || (r_estado == REPOSO && w_llam_cur)) ? w_cur : 3'b000;
  assign w_pend_nxt = (r_pend & ~w_blk) | (w_press & ~w_blk) | w_auto;

`ifdef RETORNO_PISO1_EN
  logic w_ocioso, w_ocioso_fin;
  assign w_ocioso     = (r_estado == REPOSO) && (r_pend == 3'b000) && (r_piso != 2'd1) &&
                        (w_press == 3'b000);
  assign w_ocioso_fin = w_ocioso && (r_timer == TW'(REPOSO_CICLOS - 1));
  assign w_auto       = {2'b00, w_ocioso_fin};
`else
  assign w_auto = 3'b000;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado <= REPOSO;
      r_dir    <= 1'b1;
      r_timer  <= '0;
      r_boton  <= 2'b00;
      r_puerta <= 1'b0;
      r_pend   <= 3'b000;
    end else begin
      r_pend <= w_pend_nxt;
      case (r_estado)
        REPOSO: begin
          if (w_llam_cur) begin
            r_estado <= PUERTA;
            r_puerta <= 1'b1;
            r_timer  <= '0;
          end else if (r_dir ? w_llam_up : w_llam_dn) begin
            r_estado <= PEDIR;
            r_boton  <= r_dir ? 2'b10 : 2'b01;
            r_timer  <= '0;
          end else if (r_dir ? w_llam_dn : w_llam_up) begin
            r_dir    <= ~r_dir;
            r_estado <= PEDIR;
            r_boton  <= r_dir ? 2'b01 : 2'b10;
            r_timer  <= '0;
          end else begin
`ifdef RETORNO_PISO1_EN
            if (w_ocioso && !w_ocioso_fin) r_timer <= r_timer + 1'b1;
            else                           r_timer <= '0;
`else
            r_timer <= '0;
`endif
          end
        end
        PEDIR: begin
          r_boton  <= 2'b00;
          r_estado <= ESPERA;
          r_timer  <= '0;
        end
        ESPERA: begin
          if (r_timer == TW'(TRASLADO_CICLOS - 1)) begin
            r_estado <= REPOSO;
            r_timer  <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        PUERTA: begin
          if (|(w_press & w_cur)) begin
            r_timer <= '0;
          end else if (r_timer == TW'(PUERTA_CICLOS - 1)) begin
            r_estado <= REPOSO;
            r_puerta <= 1'b0;
            r_timer  <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: r_estado <= REPOSO;
      endcase
    end
  end

  assign boton          = r_boton;
  assign dato           = r_dato;
  assign pendiente      = r_pend;
  assign puerta_abierta = r_puerta;

endmodule

// File: tb/tb_elevador_solicitudes.sv
// Bench for elevador_solicitudes with a one-cycle downstream elevator stand-in.
// Expected move/door events come from a floor-by-floor service model and are queued;
// a monitor turns boton pulses and door-open intervals into events and compares them.
module tb_elevador_solicitudes;

  localparam int PUERTA = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] llamada = 3'b000;
  logic       motorsubir, motorbajar;
  logic [1:0] boton;
  logic [3:0] dato;
  logic [2:0] pendiente;
  logic       puerta_abierta;

  always #5 clk = ~clk;

  elevador_solicitudes #(.DEB_CICLOS(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .llamada       (llamada),
    .motorsubir    (motorsubir),
    .motorbajar    (motorbajar),
    .boton         (boton),
    .dato          (dato),
    .pendiente     (pendiente),
    .puerta_abierta(puerta_abierta)
  );

  // Downstream elevator: moves one floor in response to each boton pulse.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      motorsubir <= 1'b0;
      motorbajar <= 1'b0;
    end else begin
      motorsubir <= (boton == 2'b10);
      motorbajar <= (boton == 2'b01);
    end
  end

  // kind: 1 = up pulse, 2 = down pulse, 3 = door open; piso = floor at the event; len = cycles
  typedef struct packed {
    logic [1:0] kind;
    logic [3:0] piso;
    logic [7:0] len;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  m_piso = 1;
  bit  m_dir = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic match(input ev_t got);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_event", 32'(got), 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("event", 32'(got), 32'(e));
    end
  endtask

  // Reference: serve a set of calls floor by floor, door first at the current floor,
  // otherwise keep direction while calls remain ahead, else reverse.
  task automatic plan(input logic [2:0] calls);
    logic [2:0] p;
    bit above, below;
    p = calls;
    for (int g = 0; g < 10 && p != 3'b000; g++) begin
      if (p[m_piso-1]) begin
        exp_q.push_back({2'd3, 4'(m_piso), 8'(PUERTA)});
        p[m_piso-1] = 1'b0;
      end else begin
        above = 1'b0;
        below = 1'b0;
        for (int f = 1; f <= 3; f++) begin
          if (p[f-1] && f > m_piso) above = 1'b1;
          if (p[f-1] && f < m_piso) below = 1'b1;
        end
        if (m_dir ? !above : !below) m_dir = !m_dir;
        exp_q.push_back({m_dir ? 2'd1 : 2'd2, 4'(m_piso), 8'd1});
        m_piso = m_dir ? m_piso + 1 : m_piso - 1;
      end
    end
  endtask

  // ---------------- monitor ----------------
  int         b_len = 0, d_len = 0;
  logic [1:0] b_kind = 2'b00;
  logic [3:0] b_piso = 4'd0, d_piso = 4'd0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      b_len = 0;
      d_len = 0;
    end else begin
      if (boton != 2'b00) begin
        if (b_len == 0) begin
          b_kind = (boton == 2'b10) ? 2'd1 : ((boton == 2'b01) ? 2'd2 : 2'd0);
          b_piso = dato;
        end
        b_len++;
      end else if (b_len != 0) begin
        match({b_kind, b_piso, 8'(b_len)});
        b_len = 0;
      end
      if (puerta_abierta) begin
        if (d_len == 0) d_piso = dato;
        d_len++;
      end else if (d_len != 0) begin
        match({2'd3, d_piso, 8'(d_len)});
        d_len = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    rst_n   = 1'b0;
    llamada = 3'b000;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    m_piso = 1;
    m_dir  = 1'b1;
  endtask

  task automatic press(input logic [2:0] b, input int hold);
    @(negedge clk);
    llamada = b;
    repeat (hold) @(negedge clk);
    llamada = 3'b000;
  endtask

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || puerta_abierta || boton != 2'b00) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_timeout"}, 32'(t < 3000), 32'd1);
    exp_q.delete();
    repeat (4) @(negedge clk);
    chk({nm, "_dato"}, 32'(dato), 32'(m_piso));
    chk({nm, "_pendiente"}, 32'(pendiente), 32'd0);
  endtask

  int         k;
  logic [2:0] seen;
  logic [2:0] calls;

  initial begin
    // reset
    do_reset();
    @(negedge clk);
    chk("reset_boton", 32'(boton), 32'd0);
    chk("reset_dato", 32'(dato), 32'd1);
    chk("reset_pendiente", 32'(pendiente), 32'd0);
    chk("reset_puerta", 32'(puerta_abierta), 32'd0);

    // debounce: a 3-cycle glitch is rejected
    @(negedge clk);
    llamada = 3'b100;
    repeat (3) @(negedge clk);
    llamada = 3'b000;
    seen = 3'b000;
    repeat (12) begin
      @(negedge clk);
      seen = seen | pendiente;
    end
    chk("glitch_pendiente", 32'(seen), 32'd0);

    // held press: latency 2+DEB, then travel 1 -> 3 and door at 3
    plan(3'b100);
    llamada = 3'b100;
    k = 0;
    while (pendiente[2] !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("debounce_latency", 32'(k), 32'd6);
    repeat (10 - k) @(negedge clk);
    llamada = 3'b000;
    wait_idle("travel");

    // reset in the middle of a move discards everything
    plan(3'b001);
    press(3'b001, 8);
    k = 0;
    while (boton == 2'b00 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("midmove_timeout", 32'(k < 100), 32'd1);
    do_reset();
    chk("midmove_dato", 32'(dato), 32'd1);
    chk("midmove_pendiente", 32'(pendiente), 32'd0);
    chk("midmove_boton", 32'(boton), 32'd0);
    repeat (30) @(negedge clk);
    chk("midmove_stay", 32'(dato), 32'd1);

    // direction priority: at floor 2 heading up, calls at 3 and 1
    plan(3'b010);
    press(3'b010, 8);
    wait_idle("to_floor2");
    plan(3'b101);
    press(3'b101, 8);
    wait_idle("scan");

    // current floor: door opens with no move; a re-press restarts the door timer
    exp_q.push_back({2'd3, 4'(m_piso), 8'(PUERTA + 4 + 6)});
    @(negedge clk);
    llamada = 3'b001;
    repeat (5) @(negedge clk);
    llamada = 3'b000;
    k = 0;
    while (!puerta_abierta && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("door_open_timeout", 32'(k < 50), 32'd1);
    repeat (4) @(negedge clk);
    llamada = 3'b001;
    seen = 3'b000;
    repeat (5) begin
      @(negedge clk);
      seen = seen | pendiente;
    end
    llamada = 3'b000;
    repeat (30) begin
      @(negedge clk);
      seen = seen | pendiente;
    end
    chk("door_repress_pendiente", 32'(seen), 32'd0);
    wait_idle("door_repress");

    // randomized call sets
    for (int r = 0; r < 12; r++) begin
      calls = 3'($urandom_range(1, 7));
      repeat ($urandom_range(0, 5)) @(negedge clk);
      plan(calls);
      press(calls, 6);
      wait_idle("random");
    end

    // idle behaviour at floor 3
    plan(3'b100);
    press(3'b100, 6);
    wait_idle("to_floor3");
`ifdef RETORNO_PISO1_EN
    plan(3'b001);
    wait_idle("auto_return");
`else
    repeat (100) @(negedge clk);
    chk("idle_stay_floor3", 32'(dato), 32'd3);
    chk("idle_no_call", 32'(pendiente), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    n_errors++;
    $display("FAIL watchdog: simulation did not complete, actual=running required=done");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
